// File: rtl/mem_bus_pkg.sv
// Shared encodings for the memory bus initiator: request opcodes, FSM states, latency-pipe tag.
package mem_bus_pkg;

    localparam int DEF_ADDR_WIDTH   = 16;
    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_READ_LATENCY = 1;

    typedef enum logic [1:0] {
        OP_RD_BYTE = 2'b00,
        OP_WR_BYTE = 2'b01,
        OP_RD_WORD = 2'b10,
        OP_RSVD    = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_LO,
        ISSUE_HI,
        WAIT,
        DONE
    } state_t;

    // One entry per issued read byte, travelling alongside the memory latency.
    typedef struct packed {
        logic valid;
        logic is_hi;
    } tag_t;

endpackage

// File: rtl/read_latency_pipe.sv
// Delays read tags by the memory read latency so they line up with mem_rd_data.
module read_latency_pipe
    import mem_bus_pkg::*;
#(
    parameter int STAGES = DEF_READ_LATENCY
) (
    input  logic clk,
    input  logic reset,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t [STAGES:1] vld_pipe;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= tag_in;
            for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign tag_out = vld_pipe[STAGES];

endmodule

// File: rtl/mem_bus_master.sv
// Memory bus initiator: turns core byte/word requests into registered memory strobes.
// Optional NMOS_PAGE_WRAP_EN adds req_page_wrap for in-page high-byte addressing on word reads.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
`ifdef NMOS_PAGE_WRAP_EN
    input  logic                    req_page_wrap,
`endif
    output logic                    rsp_valid,
    output logic [2*DATA_WIDTH-1:0] rsp_data,
    output logic                    mem_rd_enable,
    output logic                    mem_wr_enable,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wr_data,
    input  logic [DATA_WIDTH-1:0]   mem_rd_data,
    output logic                    busy
);

    state_t                state;
    logic                  is_write;
    logic                  is_word;
    logic                  mem_rd_hi;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] hi_addr;
    logic [DATA_WIDTH-1:0] lo_q;
    logic                  accept;
    logic                  last_byte;
    tag_t                  tag_in;
    tag_t                  tag_out;

    assign accept = req_valid && req_ready;
    assign busy   = (state != IDLE) && (state != DONE);

`ifdef NMOS_PAGE_WRAP_EN
    logic page_wrap;
    assign hi_addr = page_wrap ? {addr_q[ADDR_WIDTH-1:8], addr_q[7:0] + 8'd1}
                               : addr_q + ADDR_WIDTH'(1);
`else
    assign hi_addr = addr_q + ADDR_WIDTH'(1);
`endif

    assign tag_in = '{valid: mem_rd_enable, is_hi: mem_rd_hi};

    read_latency_pipe #(.STAGES(READ_LATENCY)) u_lat_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // A byte read finishes on its only byte; a word read finishes on the high byte.
    assign last_byte = tag_out.valid && (tag_out.is_hi || !is_word);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            req_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            mem_rd_enable <= 1'b0;
            mem_wr_enable <= 1'b0;
            mem_rd_hi     <= 1'b0;
            mem_addr      <= '0;
            mem_wr_data   <= '0;
            addr_q        <= '0;
            lo_q          <= '0;
            is_write      <= 1'b0;
            is_word       <= 1'b0;
`ifdef NMOS_PAGE_WRAP_EN
            page_wrap     <= 1'b0;
`endif
        end else begin
            rsp_valid     <= 1'b0;
            mem_rd_enable <= 1'b0;
            mem_wr_enable <= 1'b0;
            mem_rd_hi     <= 1'b0;

            if (tag_out.valid) begin
                if (tag_out.is_hi)  rsp_data <= {mem_rd_data, lo_q};
                else if (is_word)   lo_q     <= mem_rd_data;
                else                rsp_data <= {DATA_WIDTH'(0), mem_rd_data};
            end

            case (state)
                IDLE, DONE: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                    if (accept) begin
                        req_ready <= 1'b0;
                        addr_q    <= req_addr;
                        mem_addr  <= req_addr;
                        is_write  <= (req_op == OP_WR_BYTE);
                        is_word   <= (req_op == OP_RD_WORD);
`ifdef NMOS_PAGE_WRAP_EN
                        page_wrap <= req_page_wrap;
`endif
                        if (req_op == OP_WR_BYTE) begin
                            mem_wr_enable <= 1'b1;
                            mem_wr_data   <= req_wdata;
                        end else begin
                            mem_rd_enable <= 1'b1;
                        end
                        state <= ISSUE_LO;
                    end
                end
                ISSUE_LO: begin
                    if (is_write) begin
                        rsp_valid <= 1'b1;
                        req_ready <= 1'b1;
                        state     <= DONE;
                    end else if (is_word) begin
                        mem_rd_enable <= 1'b1;
                        mem_rd_hi     <= 1'b1;
                        mem_addr      <= hi_addr;
                        state         <= ISSUE_HI;
                    end else begin
                        state <= WAIT;
                    end
                end
                ISSUE_HI: state <= WAIT;
                WAIT: begin
                    if (last_byte) begin
                        rsp_valid <= 1'b1;
                        req_ready <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: one DUT per read latency 1..4, each with its own memory and scoreboard.
module tb_mem_bus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec    = 0;
    int n_err    = 0;
    int done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : lane
        localparam int L = g + 1;

        logic        rst_n, req_valid, req_ready, rsp_valid, rd_en, wr_en, busy, pw_sig;
        logic [1:0]  req_op;
        logic [15:0] req_addr, rsp_data, maddr;
        logic [7:0]  req_wdata, wdata, rdata;
        logic        bd_we;
        logic [15:0] bd_addr;
        logic [7:0]  bd_data;
        logic [7:0]  mem [0:65535];
        logic [7:0]  rd_pipe [0:L-1];
        bit   [7:0]  ref_mem [0:65535];
        logic [15:0] last_rsp;

        mem_bus_master #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .READ_LATENCY(L)) dut (
            .clk           (clk),
            .reset         (rst_n),
            .req_valid     (req_valid),
            .req_ready     (req_ready),
            .req_op        (req_op),
            .req_addr      (req_addr),
            .req_wdata     (req_wdata),
`ifdef NMOS_PAGE_WRAP_EN
            .req_page_wrap (pw_sig),
`endif
            .rsp_valid     (rsp_valid),
            .rsp_data      (rsp_data),
            .mem_rd_enable (rd_en),
            .mem_wr_enable (wr_en),
            .mem_addr      (maddr),
            .mem_wr_data   (wdata),
            .mem_rd_data   (rdata),
            .busy          (busy)
        );

        // Memory block with L-cycle read latency; 0xEE marks data from a non-read cycle.
        always @(posedge clk) begin
            if (wr_en) mem[maddr] <= wdata;
            if (bd_we) mem[bd_addr] <= bd_data;
            rd_pipe[0] <= rd_en ? mem[maddr] : 8'hEE;
            for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
        assign rdata = rd_pipe[L-1];

        function automatic string t(input string s);
            return $sformatf("L%0d %s", L, s);
        endfunction

        task automatic poke(input logic [15:0] a, input logic [7:0] d);
            bd_we = 1'b1; bd_addr = a; bd_data = d; ref_mem[a] = d;
            @(negedge clk);
            bd_we = 1'b0;
        endtask

        task automatic chk_cleared(input string ctx);
            chk(t({ctx, " req_ready"}), 32'(req_ready), 0);
            chk(t({ctx, " rsp_valid"}), 32'(rsp_valid), 0);
            chk(t({ctx, " rsp_data"}),  32'(rsp_data), 0);
            chk(t({ctx, " rd_en"}),     32'(rd_en), 0);
            chk(t({ctx, " wr_en"}),     32'(wr_en), 0);
            chk(t({ctx, " mem_addr"}),  32'(maddr), 0);
            chk(t({ctx, " wr_data"}),   32'(wdata), 0);
            chk(t({ctx, " busy"}),      32'(busy), 0);
        endtask

        // Issue one request at the current negedge and follow it to its response pulse.
        task automatic txn(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d,
                           input logic pw);
            int          exp_lat, n, rd_cnt, wr_cnt, both, bad_busy, wr_n;
            int          rd_n [2];
            logic [15:0] rd_a [2];
            logic [15:0] ha, exp_data, wr_a;
            logic [7:0]  wr_d;
            bit          got;
            ha = a + 16'd1;
`ifdef NMOS_PAGE_WRAP_EN
            if (pw) ha = {a[15:8], a[7:0] + 8'd1};
`else
            if (pw) ha = a + 16'd1;
`endif
            case (op)
                2'b01:   begin exp_lat = 2;     exp_data = last_rsp; ref_mem[a] = d; end
                2'b10:   begin exp_lat = 3 + L; exp_data = {ref_mem[ha], ref_mem[a]}; end
                default: begin exp_lat = 2 + L; exp_data = {8'h00, ref_mem[a]}; end
            endcase
            chk(t("ready_at_req"), 32'(req_ready), 1);
            req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d; pw_sig = pw;
            n = 0; got = 0; rd_cnt = 0; wr_cnt = 0; both = 0; bad_busy = 0; wr_n = 0;
            rd_n = '{0, 0}; rd_a = '{16'h0, 16'h0}; wr_a = 16'h0; wr_d = 8'h0;
            while (!got && n < 12) begin
                @(negedge clk);
                n++;
                if (rd_en && wr_en) both++;
                if (rd_en) begin
                    if (rd_cnt < 2) begin rd_n[rd_cnt] = n; rd_a[rd_cnt] = maddr; end
                    rd_cnt++;
                end
                if (wr_en) begin wr_cnt++; wr_n = n; wr_a = maddr; wr_d = wdata; end
                if (rsp_valid) begin
                    got = 1;
                end else begin
                    if (!busy || req_ready) bad_busy++;
                    // garbage that must be ignored while the block is not ready
                    req_op = 2'($urandom); req_addr = 16'($urandom); req_wdata = 8'($urandom);
                    pw_sig = 1'($urandom);
                end
            end
            req_valid = 1'b0;
            chk(t("rsp_seen"), 32'(got), 1);
            chk(t("latency"), 32'(n), 32'(exp_lat));
            chk(t("rsp_data"), 32'(rsp_data), 32'(exp_data));
            chk(t("busy_inflight"), 32'(bad_busy), 0);
            chk(t("done_busy"), 32'(busy), 0);
            chk(t("done_ready"), 32'(req_ready), 1);
            chk(t("en_overlap"), 32'(both), 0);
            if (op == 2'b01) begin
                chk(t("wr_pulses"), 32'(wr_cnt), 1);
                chk(t("wr_rd_pulses"), 32'(rd_cnt), 0);
                chk(t("wr_cycle"), 32'(wr_n), 1);
                chk(t("wr_addr"), 32'(wr_a), 32'(a));
                chk(t("wr_data"), 32'(wr_d), 32'(d));
            end else begin
                chk(t("rd_pulses"), 32'(rd_cnt), (op == 2'b10) ? 2 : 1);
                chk(t("rd_wr_pulses"), 32'(wr_cnt), 0);
                chk(t("rd_lo_cycle"), 32'(rd_n[0]), 1);
                chk(t("rd_lo_addr"), 32'(rd_a[0]), 32'(a));
                if (op == 2'b10) begin
                    chk(t("rd_hi_cycle"), 32'(rd_n[1]), 2);
                    chk(t("rd_hi_addr"), 32'(rd_a[1]), 32'(ha));
                end
                last_rsp = exp_data;
            end
        endtask

        initial begin : drv
            int          pulses;
            logic [15:0] bases [4];
            bases = '{16'h0000, 16'h10F8, 16'hFFF8, 16'h0200};
            rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_addr = 16'h0; req_wdata = 8'h0;
            pw_sig = 1'b0; bd_we = 1'b0; bd_addr = 16'h0; bd_data = 8'h0; last_rsp = 16'h0;
            repeat (3) @(negedge clk);
            chk_cleared("reset");
            rst_n = 1'b1;
            #1 chk(t("ready_before_clk"), 32'(req_ready), 0);
            @(negedge clk);
            chk(t("ready_after_release"), 32'(req_ready), 1);

            for (int i = 0; i < 9; i++) begin
                poke(16'h0000 + 16'(i), 8'($urandom));
                poke(16'h0200 + 16'(i), 8'($urandom));
                poke(16'h10F8 + 16'(i), 8'($urandom));
            end
            for (int i = 0; i < 8; i++) poke(16'hFFF8 + 16'(i), 8'($urandom));
            poke(16'h0200, 8'hA5); poke(16'hFFFC, 8'h00); poke(16'hFFFD, 8'h80);
            poke(16'hFFFF, 8'h34); poke(16'h0000, 8'h12); poke(16'h10FF, 8'h56);
            poke(16'h1000, 8'h78); poke(16'h1100, 8'h9A);

            txn(2'b00, 16'h0200, 8'h00, 1'b0);
            chk(t("byte_read_a5"), 32'(rsp_data), 32'h00A5);
            txn(2'b01, 16'h0300, 8'h5C, 1'b0);
            txn(2'b00, 16'h0300, 8'h00, 1'b0);
            chk(t("readback_5c"), 32'(rsp_data), 32'h005C);
            txn(2'b10, 16'hFFFC, 8'h00, 1'b0);
            chk(t("reset_vector"), 32'(rsp_data), 32'h8000);
            txn(2'b10, 16'hFFFF, 8'h00, 1'b0);
            chk(t("addr_wrap"), 32'(rsp_data), 32'h1234);
            txn(2'b10, 16'h10FF, 8'h00, 1'b1);
`ifdef NMOS_PAGE_WRAP_EN
            chk(t("page_wrap_on"), 32'(rsp_data), 32'h7856);
`else
            chk(t("page_wrap_absent"), 32'(rsp_data), 32'h9A56);
`endif
            txn(2'b10, 16'h10FF, 8'h00, 1'b0);
            chk(t("page_cross"), 32'(rsp_data), 32'h9A56);
            txn(2'b11, 16'h0200, 8'h00, 1'b0);
            chk(t("reserved_op"), 32'(rsp_data), 32'h00A5);

            // Reset lands in the middle of a word read.
            req_valid = 1'b1; req_op = 2'b10; req_addr = 16'hFFFC; req_wdata = 8'h0; pw_sig = 1'b0;
            @(negedge clk);
            req_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b0;
            #1 chk_cleared("mid_reset");
            pulses = 0;
            repeat (2) begin @(negedge clk); if (rsp_valid) pulses++; end
            rst_n = 1'b1;
            @(negedge clk);
            chk(t("ready_after_abort"), 32'(req_ready), 1);
            repeat (L + 4) begin if (rsp_valid) pulses++; @(negedge clk); end
            chk(t("no_rsp_after_abort"), 32'(pulses), 0);
            last_rsp = 16'h0;
            txn(2'b00, 16'h0200, 8'h00, 1'b0);
            chk(t("after_abort_read"), 32'(rsp_data), 32'h00A5);

            for (int k = 0; k < 150; k++) begin
                txn(2'($urandom_range(0, 3)), bases[$urandom_range(0, 3)] + 16'($urandom_range(0, 7)),
                    8'($urandom), 1'($urandom_range(0, 1)));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            done_cnt++;
        end
    end

    initial begin
        for (int c = 0; c < 40000; c++) begin
            if (done_cnt == 4) break;
            @(posedge clk);
        end
        if (done_cnt != 4) chk("watchdog lanes_done", 32'(done_cnt), 4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
